// File: rtl/sign_magnitude_decoder.sv
// sign_magnitude_decoder: bit-serial two's-complement to sign-magnitude converter, LSB first.
// Optional build macro SIGNMAG_SATURATE_EN clamps the most-negative input to 2^(WIDTH-1)-1.
`default_nettype none

module sign_magnitude_decoder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [WIDTH-1:0] out_magnitude,
    output logic             out_zero,
    output logic             out_min_neg,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`ifdef SIGNMAG_SATURATE_EN
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] mag_q;
    logic [CW-1:0]    count_q;
    logic             sign_q;
    logic             seen_q;
    logic             zero_q;
    logic             min_neg_q;

    logic             bit_d;
    logic [WIDTH-1:0] mag_d;
    logic             last_d;
    logic             min_neg_d;

    // Serial complement: bits pass unchanged until the first 1 has gone by, then invert.
    always_comb begin
        bit_d     = shift_q[0] ^ (sign_q & seen_q);
        mag_d     = {bit_d, mag_q[WIDTH-1:1]};
        last_d    = (count_q == CW'(WIDTH - 1));
        min_neg_d = sign_q && (mag_d == MIN_NEG);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            mag_q     <= '0;
            count_q   <= '0;
            sign_q    <= 1'b0;
            seen_q    <= 1'b0;
            zero_q    <= 1'b0;
            min_neg_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        state_q   <= S_SHIFT;
                        shift_q   <= in_word;
                        sign_q    <= in_word[WIDTH-1];
                        seen_q    <= 1'b0;
                        count_q   <= '0;
                        mag_q     <= '0;
                        zero_q    <= 1'b0;
                        min_neg_q <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    shift_q <= {1'b0, shift_q[WIDTH-1:1]};
                    seen_q  <= seen_q | shift_q[0];
                    count_q <= count_q + CW'(1);
                    mag_q   <= mag_d;
                    if (last_d) begin
                        state_q   <= S_DONE;
                        zero_q    <= (mag_d == '0);
                        min_neg_q <= min_neg_d;
`ifdef SIGNMAG_SATURATE_EN
                        if (min_neg_d) begin
                            mag_q <= MAX_POS;
                        end
`endif
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready      = (state_q == S_IDLE);
    assign busy          = (state_q == S_SHIFT);
    assign out_valid     = (state_q == S_DONE);
    assign out_sign      = sign_q;
    assign out_magnitude = mag_q;
    assign out_zero      = zero_q;
    assign out_min_neg   = min_neg_q;

endmodule

`default_nettype wire

// File: tb/tb_sign_magnitude_decoder.sv
// Directed and randomized bench for sign_magnitude_decoder.
`timescale 1ns/1ps
`default_nettype none

module tb_sign_magnitude_decoder;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_word = '0;
    logic         in_ready;
    logic         out_valid;
    logic         out_sign;
    logic [W-1:0] out_magnitude;
    logic         out_zero;
    logic         out_min_neg;
    logic         busy;

    int total = 0;
    int bad = 0;
    int hs_cnt = 0;

    sign_magnitude_decoder #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_word       (in_word),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_sign      (out_sign),
        .out_magnitude (out_magnitude),
        .out_zero      (out_zero),
        .out_min_neg   (out_min_neg),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1);
    end

    // Offer a word and return #1 after the edge that accepts it.
    task automatic send(input logic [W-1:0] w);
        in_valid = 1'b1;
        in_word  = w;
        for (int i = 0; i < 200; i++) begin
            if (in_ready) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                in_word  = W'($urandom);
                return;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        total++; bad++;
        $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
    endtask

    // Edges counted inclusively from the accept edge; -1 if out_valid never rose.
    task automatic wait_valid(output int edges, output int busy_cnt);
        edges    = 1;
        busy_cnt = 0;
        for (int i = 0; i < 4 * W; i++) begin
            if (out_valid) return;
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            edges++;
        end
        edges = -1;
    endtask

    task automatic pop();
        out_ready = 1'b1;
        if (out_valid) hs_cnt++;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({in_ready, out_valid, busy, out_sign, out_zero, out_min_neg} !== 6'b100000) begin
            bad++;
            $display("FAIL reset_flags: got rdy/vld/busy/sgn/zero/mn=%b required 100000",
                     {in_ready, out_valid, busy, out_sign, out_zero, out_min_neg});
        end
        total++;
        if (out_magnitude !== 16'h0000) begin
            bad++;
            $display("FAIL reset_mag: got %h required 0000", out_magnitude);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_negative();
        int e, b;
        out_ready = 1'b1;
        send(16'hFFFB);
        total++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL neg_start: in_ready=%b busy=%b required 0 1", in_ready, busy);
        end
        wait_valid(e, b);
        total++;
        if (b != W || e != W + 1) begin
            bad++;
            $display("FAIL neg_latency: busy=%0d edges=%0d required %0d %0d", b, e, W, W + 1);
        end
        total++;
        if ({out_sign, out_zero, out_min_neg} !== 3'b100 || out_magnitude !== 16'h0005) begin
            bad++;
            $display("FAIL neg_result: sgn/zero/mn=%b mag=%h required 100 0005",
                     {out_sign, out_zero, out_min_neg}, out_magnitude);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL neg_return: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_values();
        int e, b;
        send(16'h007F);
        wait_valid(e, b);
        total++;
        if (e != W + 1 || out_sign !== 1'b0 || out_magnitude !== 16'h007F || out_zero !== 1'b0) begin
            bad++;
            $display("FAIL pos_7f: edges=%0d sgn=%b mag=%h zero=%b required %0d 0 007f 0",
                     e, out_sign, out_magnitude, out_zero, W + 1);
        end
        pop();
        send(16'h0000);
        wait_valid(e, b);
        total++;
        if (e != W + 1 || out_sign !== 1'b0 || out_magnitude !== 16'h0000 || out_zero !== 1'b1
            || out_min_neg !== 1'b0) begin
            bad++;
            $display("FAIL zero_in: edges=%0d sgn=%b mag=%h zero=%b mn=%b required %0d 0 0000 1 0",
                     e, out_sign, out_magnitude, out_zero, out_min_neg, W + 1);
        end
        pop();
    endtask

    task automatic test_min_neg();
        int e, b;
        logic [W-1:0] exp_mag;
`ifdef SIGNMAG_SATURATE_EN
        exp_mag = 16'h7FFF;
`else
        exp_mag = 16'h8000;
`endif
        send(16'h8000);
        wait_valid(e, b);
        total++;
        if (out_sign !== 1'b1 || out_min_neg !== 1'b1 || out_zero !== 1'b0 || out_magnitude !== exp_mag) begin
            bad++;
            $display("FAIL min_neg: sgn=%b mn=%b zero=%b mag=%h required 1 1 0 %h",
                     out_sign, out_min_neg, out_zero, out_magnitude, exp_mag);
        end
        pop();
    endtask

    task automatic test_backpressure();
        int e, b;
        send(16'hFF00);
        in_valid = 1'b1;
        in_word  = 16'h0001;
        wait_valid(e, b);
        for (int i = 0; i < 10; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_magnitude !== 16'h0100 || out_sign !== 1'b1 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL hold_%0d: vld=%b mag=%h sgn=%b rdy=%b required 1 0100 1 0",
                         i, out_valid, out_magnitude, out_sign, in_ready);
            end
            @(posedge clk); #1;
        end
        pop();
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL second_accept: busy=%b required 1", busy);
        end
        wait_valid(e, b);
        total++;
        if (e != W + 1 || out_magnitude !== 16'h0001 || out_sign !== 1'b0) begin
            bad++;
            $display("FAIL second_word: edges=%0d mag=%h sgn=%b required %0d 0001 0",
                     e, out_magnitude, out_sign, W + 1);
        end
        pop();
    endtask

    task automatic test_reset_abort();
        int e, b;
        send(16'hFFFF);
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        total++;
        if ({in_ready, out_valid, busy, out_sign, out_zero, out_min_neg} !== 6'b100000
            || out_magnitude !== 16'h0000) begin
            bad++;
            $display("FAIL abort: rdy/vld/busy/sgn/zero/mn=%b mag=%h required 100000 0000",
                     {in_ready, out_valid, busy, out_sign, out_zero, out_min_neg}, out_magnitude);
        end
        send(16'hFFFF);
        wait_valid(e, b);
        total++;
        if (e != W + 1 || out_sign !== 1'b1 || out_magnitude !== 16'h0001) begin
            bad++;
            $display("FAIL after_abort: edges=%0d sgn=%b mag=%h required %0d 1 0001",
                     e, out_sign, out_magnitude, W + 1);
        end
        pop();
    endtask

    task automatic test_random();
        int e, b, hs0;
        logic [W-1:0] w, em;
        logic es, ez, en;
        hs0 = hs_cnt;
        for (int n = 0; n < 1000; n++) begin
            w = W'($urandom);
            if (n == 0) w = 16'h8000;
            if (n == 1) w = 16'h7FFF;
            es = w[W-1];
            em = es ? (~w + 16'h0001) : w;
            ez = (w == 16'h0000);
            en = (w == 16'h8000);
`ifdef SIGNMAG_SATURATE_EN
            if (en) em = 16'h7FFF;
`endif
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #0;
            send(w);
            wait_valid(e, b);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #0;
            total++;
            if (out_valid !== 1'b1 || e != W + 1 || out_sign !== es || out_magnitude !== em
                || out_zero !== ez || out_min_neg !== en) begin
                bad++;
                $display("FAIL rand_%0d: in=%h vld=%b edges=%0d sgn=%b mag=%h zero=%b mn=%b required 1 %0d %b %h %b %b",
                         n, w, out_valid, e, out_sign, out_magnitude, out_zero, out_min_neg,
                         W + 1, es, em, ez, en);
            end
            pop();
        end
        total++;
        if (hs_cnt - hs0 != 1000) begin
            bad++;
            $display("FAIL rand_count: handshakes=%0d required 1000", hs_cnt - hs0);
        end
    endtask

    initial begin
        test_reset();
        test_negative();
        test_values();
        test_min_neg();
        test_backpressure();
        test_reset_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
